// File: rtl/pic_priority_engine.sv
// pic_priority_engine: clocked 8259-style priority resolver with IRR/ISR, rotating priority and INTA handshake.
// Optional macro PIC_SPECIAL_MASK_EN adds special_mask (nested check against isr & ~imr).
module pic_priority_engine #(
   parameter  int NUM_IRQ     = 8,
   parameter  int SPURIOUS_ID = NUM_IRQ - 1,
   localparam int ID_W        = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               level_mode,
   input  logic [NUM_IRQ-1:0] imr,
   input  logic               auto_eoi,
   input  logic               rotate_on_eoi,
   input  logic               int_ack,
   input  logic               eoi,
   input  logic               eoi_specific,
   input  logic [ID_W-1:0]    eoi_id,
   input  logic               set_prio,
   input  logic [ID_W-1:0]    set_prio_id,
   output logic               int_req,
   output logic [ID_W-1:0]    int_id,
   output logic               int_id_valid,
   output logic               spurious,
   output logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] isr
`ifdef PIC_SPECIAL_MASK_EN
   ,
   input  logic               special_mask
`endif
);

   typedef enum logic [1:0] {IDLE, PEND, GRANT} state_t;

   state_t             state, state_nxt;
   logic [NUM_IRQ-1:0] irq_q;
   logic [ID_W-1:0]    prio_base, base_nxt;
   logic [NUM_IRQ-1:0] req_vec, isr_cmp;
   logic [ID_W:0]      cand_rank, isr_rank, eoi_rank;
   logic [ID_W-1:0]    cand_id, eoi_top;
   logic               cand_valid, ack_grant, ack_spur;
   logic [NUM_IRQ-1:0] grant_hot, irr_set, irr_clr, isr_set, isr_clr;

   // Channel at priority offset 'off' from base, wrapping modulo NUM_IRQ.
   function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input logic [ID_W:0] off);
      logic [ID_W+1:0] s;
      s = {2'b00, base} + {1'b0, off};
      if (s >= (ID_W+2)'(NUM_IRQ)) s = s - (ID_W+2)'(NUM_IRQ);
      return s[ID_W-1:0];
   endfunction

   // Priority offset of the highest-priority set bit; NUM_IRQ when vec is empty.
   function automatic logic [ID_W:0] top_rank(input logic [NUM_IRQ-1:0] vec, input logic [ID_W-1:0] base);
      logic [ID_W:0] r;
      r = (ID_W+1)'(NUM_IRQ);
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (vec[rot_idx(base, (ID_W+1)'(i))]) r = (ID_W+1)'(i);
      return r;
   endfunction

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
      if (int'(x) >= NUM_IRQ - 1) return '0;
      return x + 1'b1;
   endfunction

   assign req_vec = irr & ~imr;
`ifdef PIC_SPECIAL_MASK_EN
   assign isr_cmp = special_mask ? (isr & ~imr) : isr;
`else
   assign isr_cmp = isr;
`endif

   assign cand_rank  = top_rank(req_vec, prio_base);
   assign isr_rank   = top_rank(isr_cmp, prio_base);
   assign eoi_rank   = top_rank(isr, prio_base);
   assign cand_id    = rot_idx(prio_base, cand_rank);
   assign eoi_top    = rot_idx(prio_base, eoi_rank);
   // An empty isr_cmp ranks as NUM_IRQ, so this also covers the isr == 0 case.
   assign cand_valid = cand_rank < isr_rank;
   assign ack_grant  = int_ack && (state == PEND) && cand_valid;
   assign ack_spur   = int_ack && !ack_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cand_valid) state_nxt = PEND;
         PEND: begin
            if (ack_grant)        state_nxt = GRANT;
            else if (!cand_valid) state_nxt = IDLE;
         end
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_hot = ack_grant ? (NUM_IRQ'(1) << cand_id) : '0;
      irr_set   = level_mode ? irq_in : (irq_in & ~irq_q);
      irr_clr   = (level_mode ? ~irq_in : '0) | grant_hot;
      isr_set   = auto_eoi ? '0 : grant_hot;
      isr_clr   = '0;
      // Out-of-range eoi_id shifts the one-hot past the top bit, so it clears nothing.
      if (eoi) begin
         if (eoi_specific)                      isr_clr = NUM_IRQ'(1) << eoi_id;
         else if (isr != '0)                    isr_clr = NUM_IRQ'(1) << eoi_top;
      end
      base_nxt = prio_base;
      if (set_prio)                                          base_nxt = next_id(set_prio_id);
      else if (eoi && !eoi_specific && rotate_on_eoi && isr != '0) base_nxt = next_id(eoi_top);
      else if (ack_grant && auto_eoi && rotate_on_eoi)       base_nxt = next_id(cand_id);
   end

   // Set terms are OR-ed in after clears so a same-cycle set always wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_req      <= 1'b0;
         int_id       <= '0;
         int_id_valid <= 1'b0;
         spurious     <= 1'b0;
         irr          <= '0;
         isr          <= '0;
         irq_q        <= '0;
         prio_base    <= '0;
      end else begin
         int_req      <= (state_nxt == PEND);
         int_id_valid <= int_ack;
         spurious     <= ack_spur;
         if (ack_grant)     int_id <= cand_id;
         else if (ack_spur) int_id <= ID_W'(SPURIOUS_ID);
         irr          <= (irr & ~irr_clr) | irr_set;
         isr          <= (isr & ~isr_clr) | isr_set;
         irq_q        <= irq_in;
         prio_base    <= base_nxt;
      end
   end

endmodule

// File: tb/tb_pic_priority_engine.sv
// Bench for pic_priority_engine: directed scenarios plus random traffic against a rule-level reference model.
module tb_pic_priority_engine;
   localparam int N  = 8;
   localparam int IW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  irq_in, imr;
   logic          level_mode, auto_eoi, rotate_on_eoi;
   logic          int_ack, eoi, eoi_specific, set_prio;
   logic [IW-1:0] eoi_id, set_prio_id;
   logic          int_req, int_id_valid, spurious;
   logic [IW-1:0] int_id;
   logic [N-1:0]  irr, isr;
`ifdef PIC_SPECIAL_MASK_EN
   logic          special_mask;
`endif

   pic_priority_engine #(.NUM_IRQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .level_mode(level_mode), .imr(imr),
      .auto_eoi(auto_eoi), .rotate_on_eoi(rotate_on_eoi), .int_ack(int_ack), .eoi(eoi),
      .eoi_specific(eoi_specific), .eoi_id(eoi_id), .set_prio(set_prio), .set_prio_id(set_prio_id),
      .int_req(int_req), .int_id(int_id), .int_id_valid(int_id_valid), .spurious(spurious),
      .irr(irr), .isr(isr)
`ifdef PIC_SPECIAL_MASK_EN
      , .special_mask(special_mask)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: registers as bit vectors, priority pointer as a plain integer.
   logic [N-1:0]  m_irr, m_isr, m_prev;
   int            m_base;
   logic          m_req, m_grant, m_vld, m_spur;
   logic [IW-1:0] m_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rank(input int ch);
      return (ch - m_base + N) % N;
   endfunction

   function automatic int top(input logic [N-1:0] v);
      int best = -1;
      for (int i = 0; i < N; i++)
         if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
      return best;
   endfunction

   task automatic model_reset();
      m_irr = '0; m_isr = '0; m_prev = '0; m_base = 0;
      m_req = 0; m_grant = 0; m_vld = 0; m_spur = 0; m_id = '0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".int_req"},  32'(int_req),      32'(m_req));
      chk({tag, ".valid"},    32'(int_id_valid), 32'(m_vld));
      chk({tag, ".spurious"}, 32'(spurious),     32'(m_spur));
      chk({tag, ".int_id"},   32'(int_id),       32'(m_id));
      chk({tag, ".irr"},      32'(irr),          32'(m_irr));
      chk({tag, ".isr"},      32'(isr),          32'(m_isr));
   endtask

   // One clock: evaluate the rules on current inputs, clock the DUT, compare, drop pulses.
   task automatic tick();
      logic [N-1:0] cmpv, setv, nirr, nisr;
      int  cand, itop, etop, nb;
      bit  cv, ackg, nreq;
      cand = top(m_irr & ~imr);
      cmpv = m_isr;
`ifdef PIC_SPECIAL_MASK_EN
      if (special_mask) cmpv = m_isr & ~imr;
`endif
      itop = top(cmpv);
      etop = top(m_isr);
      cv   = (cand >= 0) && (itop < 0 || rank(cand) < rank(itop));
      ackg = int_ack && m_req && cv;
      setv = level_mode ? irq_in : (irq_in & ~m_prev);
      nirr = m_irr;
      if (level_mode) nirr = nirr & irq_in;
      if (ackg) nirr = nirr & ~(N'(1) << cand);
      nirr = nirr | setv;
      nisr = m_isr;
      if (eoi) begin
         if (eoi_specific) nisr = nisr & ~(N'(1) << eoi_id);
         else if (etop >= 0) nisr = nisr & ~(N'(1) << etop);
      end
      if (ackg && !auto_eoi) nisr = nisr | (N'(1) << cand);
      nb = m_base;
      if (set_prio) nb = (int'(set_prio_id) + 1) % N;
      else if (eoi && !eoi_specific && rotate_on_eoi && etop >= 0) nb = (etop + 1) % N;
      else if (ackg && auto_eoi && rotate_on_eoi) nb = (cand + 1) % N;
      nreq = cv && !m_grant && !(int_ack && m_req);
      @(posedge clk);
      #1;
      m_vld  = int_ack;
      m_spur = int_ack && !ackg;
      if (ackg) m_id = IW'(cand);
      else if (int_ack) m_id = IW'(N - 1);
      m_grant = ackg;
      m_req   = nreq;
      m_irr   = nirr;
      m_isr   = nisr;
      m_prev  = irq_in;
      m_base  = nb;
      check_all("cyc");
      int_ack = 0; eoi = 0; set_prio = 0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (int_req !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk(tag, 32'(int_req), 32'd1);
   endtask

   initial begin
      rst_n = 0; irq_in = '0; imr = '0; level_mode = 0; auto_eoi = 0; rotate_on_eoi = 0;
      int_ack = 0; eoi = 0; eoi_specific = 0; eoi_id = '0; set_prio = 0; set_prio_id = '0;
`ifdef PIC_SPECIAL_MASK_EN
      special_mask = 0;
`endif
      model_reset();
      #12;
      chk("rst.int_req", 32'(int_req), 32'd0);
      chk("rst.irr", 32'(irr), 32'd0);
      chk("rst.isr", 32'(isr), 32'd0);
      chk("rst.valid", 32'(int_id_valid), 32'd0);
      chk("rst.int_id", 32'(int_id), 32'd0);
      @(negedge clk);
      rst_n = 1;

      // Edge mode, fully nested: 3 then 5
      irq_in = 8'h28; tick();
      chk("edge.irr", 32'(irr), 32'h28);
      chk("edge.req_lat", 32'(int_req), 32'd0);
      irq_in = '0; tick();
      chk("edge.req", 32'(int_req), 32'd1);
      int_ack = 1; tick();
      chk("edge.id3", 32'(int_id), 32'd3);
      chk("edge.isr08", 32'(isr), 32'h08);
      chk("edge.irr20", 32'(irr), 32'h20);
      tick(); tick();
      chk("edge.nested", 32'(int_req), 32'd0);
      eoi = 1; tick();
      chk("edge.eoi", 32'(isr), 32'h00);
      wait_req("edge.req5");
      int_ack = 1; tick();
      chk("edge.id5", 32'(int_id), 32'd5);
      eoi = 1; tick();

      // Rotate on non-specific EOI
      rotate_on_eoi = 1;
      irq_in = 8'h04; tick(); irq_in = '0;
      wait_req("rot.req2");
      int_ack = 1; tick();
      chk("rot.id2", 32'(int_id), 32'd2);
      eoi = 1; tick();
      irq_in = 8'h11; tick(); irq_in = '0;
      wait_req("rot.req4");
      int_ack = 1; tick();
      chk("rot.id4", 32'(int_id), 32'd4);
      eoi = 1; tick();
      wait_req("rot.req0");
      int_ack = 1; tick();
      chk("rot.id0", 32'(int_id), 32'd0);
      eoi = 1; tick();
      rotate_on_eoi = 0;

      // Level mode request withdrawn before acknowledge
      level_mode = 1;
      irq_in = 8'h02; tick();
      wait_req("lvl.req");
      irq_in = '0; tick();
      chk("lvl.irr_drop", 32'(irr[1]), 32'd0);
      tick();
      chk("lvl.req_low", 32'(int_req), 32'd0);
      int_ack = 1; tick();
      chk("lvl.spurious", 32'(spurious), 32'd1);
      chk("lvl.spur_id", 32'(int_id), 32'd7);
      chk("lvl.spur_vld", 32'(int_id_valid), 32'd1);
      level_mode = 0; tick();

      // Auto-EOI grant leaves ISR clear
      auto_eoi = 1;
      irq_in = 8'h40; tick(); irq_in = '0;
      wait_req("aeoi.req");
      int_ack = 1; tick();
      chk("aeoi.id6", 32'(int_id), 32'd6);
      chk("aeoi.isr", 32'(isr), 32'h00);
      tick();
      chk("aeoi.one_pulse", 32'(int_id_valid), 32'd0);
      auto_eoi = 0;

      // Specific rotate to base 5, then specific EOIs
      set_prio_id = 3'd4; set_prio = 1; tick();
      irq_in = 8'h28; tick(); irq_in = '0;
      wait_req("sp.req5");
      int_ack = 1; tick();
      chk("sp.id5", 32'(int_id), 32'd5);
      eoi = 1; eoi_specific = 1; eoi_id = 3'd3; tick();
      chk("sp.eoi3_noop", 32'(isr), 32'h20);
      eoi = 1; eoi_specific = 1; eoi_id = 3'd5; tick();
      chk("sp.eoi5", 32'(isr), 32'h00);
      eoi_specific = 0;
      wait_req("sp.req3");
      int_ack = 1; tick();
      chk("sp.id3", 32'(int_id), 32'd3);
      chk("sp.isr08", 32'(isr), 32'h08);
      eoi = 1; tick();

      // Asynchronous reset in the middle of a handshake
      irq_in = 8'h01; tick(); irq_in = '0;
      wait_req("arst.req");
      #2 rst_n = 0; int_ack = 1;
      #1;
      model_reset();
      chk("arst.int_req", 32'(int_req), 32'd0);
      chk("arst.irr", 32'(irr), 32'd0);
      chk("arst.isr", 32'(isr), 32'd0);
      @(posedge clk); #1;
      int_ack = 0; rst_n = 1;
      tick();

`ifdef PIC_SPECIAL_MASK_EN
      irq_in = 8'h04; tick(); irq_in = '0;
      wait_req("smm.req2");
      int_ack = 1; tick();
      imr = 8'h04; irq_in = 8'h40; tick(); irq_in = '0;
      tick(); tick();
      chk("smm.blocked", 32'(int_req), 32'd0);
      special_mask = 1;
      wait_req("smm.req6");
      int_ack = 1; tick();
      chk("smm.id6", 32'(int_id), 32'd6);
      special_mask = 0; imr = '0;
      eoi = 1; tick(); eoi = 1; tick();
`endif

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) irq_in = N'($urandom & $urandom);
         if ($urandom_range(0, 63) == 0) level_mode = ~level_mode;
         if ($urandom_range(0, 15) == 0) imr = N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 31) == 0) begin
            auto_eoi = 1'($urandom_range(0, 1));
            rotate_on_eoi = 1'($urandom_range(0, 1));
         end
         int_ack = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         eoi = ($urandom_range(0, 5) == 0);
         eoi_specific = 1'($urandom_range(0, 1));
         eoi_id = IW'($urandom_range(0, N - 1));
         set_prio = ($urandom_range(0, 24) == 0);
         set_prio_id = IW'($urandom_range(0, N - 1));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
